sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of stored word.
REQ-002 SHALL provide parameter ADDR_W, default 6, RAM address width; depth = 2**ADDR_W (64).
REQ-003 SHALL provide port clk  input  1  single clock for all logic; also drives both RAM clocks.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port push  input  1  write request, user side.
REQ-006 SHALL provide port push_data  input  DATA_W  word to store.
REQ-007 SHALL provide port pop  input  1  read request, user side.
REQ-008 SHALL provide port pop_data  output  DATA_W  popped word, valid when pop_valid=1.
REQ-009 SHALL provide port pop_valid  output  1  pop_data qualifier.
REQ-010 SHALL provide port full  output  1  count == depth.
REQ-011 SHALL provide port empty  output  1  count == 0.
REQ-012 SHALL provide port count  output  ADDR_W+1  stored words, 0..64.
REQ-013 SHALL provide port overflow  output  1  one-cycle pulse, push rejected.
REQ-014 SHALL provide port underflow  output  1  one-cycle pulse, pop rejected.
REQ-015 SHALL provide port ram_we  output  1  RAM write enable.
REQ-016 SHALL provide port ram_waddr  output  ADDR_W  RAM write address.
REQ-017 SHALL provide port ram_wdata  output  DATA_W  RAM write data.
REQ-018 SHALL provide port ram_re  output  1  RAM read enable.
REQ-019 SHALL provide port ram_raddr  output  ADDR_W  RAM read address.
REQ-020 SHALL provide port ram_rdata  input  DATA_W  RAM read data, valid one clk after ram_re sampled high.

Function
REQ-021 Push accepted iff push=1 and full=0; accepted push SHALL drive ram_we=1, ram_waddr=wr_ptr, ram_wdata=push_data combinationally in the same cycle.
REQ-022 Pop accepted iff pop=1 and empty=0; accepted pop SHALL drive ram_re=1, ram_raddr=rd_ptr combinationally in the same cycle.
REQ-023 ram_we/ram_re SHALL be 0 whenever no push/pop is accepted.
REQ-024 wr_ptr/rd_ptr SHALL be ADDR_W-bit registers, increment by 1 on accepted push/pop, wrap 63 -> 0.
REQ-025 count SHALL update on the clk edge: +1 push only, -1 pop only, unchanged for both or neither.
REQ-026 full/empty SHALL be decoded from registered count (no combinational path from push/pop).
REQ-027 Simultaneous push+pop with 0<count<64: both accepted, count unchanged.
REQ-028 Push+pop at full: pop accepted, push rejected, overflow pulses; count -> 63.
REQ-029 Push+pop at empty: push accepted, pop rejected, underflow pulses; count -> 1; no fall-through.
REQ-030 pop_valid SHALL be a register set one cycle after an accepted pop, for exactly one cycle per pop; pop_data SHALL equal ram_rdata in that cycle, read latency 1.
REQ-031 overflow/underflow SHALL be registered, high one cycle after the rejected request.
REQ-032 Data order SHALL be strict first-in first-out across pointer wrap.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, count, pop_valid, overflow, underflow; empty=1, full=0.
REQ-034 During reset ram_we and ram_re SHALL be 0; RAM contents are not cleared and are treated as invalid.
REQ-035 Reset mid-operation SHALL discard all stored words and any pending pop_valid; first push after release writes address 0.

Verification
REQ-036 Reset, push 15 -> ram_we=1, waddr=0, count=1, empty=0; pop next cycle -> ram_re=1, raddr=0; following cycle pop_valid=1, pop_data=15, count=0.
REQ-037 Push 64 words 0..63 -> full=1, count=64; 65th push -> overflow=1 next cycle, count stays 64; pop all -> data 0..63 in order, empty=1.
REQ-038 Pop while empty -> underflow=1 one cycle later, ram_re=0, pop_valid stays 0, count=0.
REQ-039 Fill to 60, then 10 cycles push+pop with data 100..109 -> pointers wrap past 63, count stays 60, ordering preserved when drained.
REQ-040 Push 5 words, assert rst_n=0 mid-cycle -> outputs cleared immediately; after release push 32 then pop -> raddr=0, pop_data=32.
REQ-041 Full, push+pop same cycle -> overflow=1, count=63, pop_data = oldest word.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external synchronous RAM (read latency 1).
// Tracks occupancy, gates RAM strobes, and flags rejected pushes/pops.
module sync_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_r;
    logic              pop_vld_p1;
    logic              overflow_p1;
    logic              underflow_p1;
    logic              push_acc;
    logic              pop_acc;

    // Flags come only from the registered count, never from push/pop.
    assign full  = (count_r == DEPTH);
    assign empty = (count_r == '0);
    assign count = count_r;

    // rst_n gating keeps the RAM strobes low while reset is held.
    assign push_acc = push && !full && rst_n;
    assign pop_acc  = pop && !empty && rst_n;

    assign ram_we    = push_acc;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = push_data;
    assign ram_re    = pop_acc;
    assign ram_raddr = rd_ptr;

    assign pop_data  = ram_rdata;
    assign pop_valid = pop_vld_p1;
    assign overflow  = overflow_p1;
    assign underflow = underflow_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Stage 1: RAM read data returns alongside its qualifier and the reject pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_vld_p1   <= 1'b0;
            overflow_p1  <= 1'b0;
            underflow_p1 <= 1'b0;
        end else begin
            pop_vld_p1   <= pop_acc;
            overflow_p1  <= push && full;
            underflow_p1 <= pop && empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_sync_fifo_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b1;
        push_data = 32'd7;
        pop       = 1'b1;
        ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push then pop of 15.
        push = 1'b1; push_data = 32'd15;
        #1;
        chk("p15_we", ram_we, 1);
        chk("p15_waddr", ram_waddr, 0);
        chk("p15_wdata", ram_wdata, 15);
        step();
        push = 1'b0; pop = 1'b1;
        chk("p15_count1", count, 1);
        chk("p15_empty", empty, 0);
        #1;
        chk("p15_re", ram_re, 1);
        chk("p15_raddr", ram_raddr, 0);
        step();
        pop = 1'b0;
        chk("p15_pop_valid", pop_valid, 1);
        chk("p15_pop_data", pop_data, 15);
        chk("p15_count0", count, 0);
        step();
        chk("p15_pop_valid_drop", pop_valid, 0);

        // Fill 0..63, reject the 65th, drain in order.
        for (int i = 0; i < 64; i++) begin
            push = 1'b1; push_data = DATA_W'(i);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 64);
        push_data = 32'd64;
        #1;
        chk("ovf_we", ram_we, 0);
        step();
        push = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 64);
        step();
        chk("ovf_clear", overflow, 0);
        for (int i = 0; i < 64; i++) begin
            pop = 1'b1;
            step();
            chk("drain_valid", pop_valid, 1);
            chk("drain_data", pop_data, 64'(i));
        end
        pop = 1'b0;
        chk("drain_empty", empty, 1);
        step();
        chk("drain_valid_drop", pop_valid, 0);

        // Pop while empty.
        pop = 1'b1;
        #1;
        chk("udf_re", ram_re, 0);
        step();
        pop = 1'b0;
        chk("udf_pulse", underflow, 1);
        chk("udf_pop_valid", pop_valid, 0);
        chk("udf_count", count, 0);
        step();
        chk("udf_clear", underflow, 0);

        // Pointers sit at 1; fill 60 (200..259), then 10 push+pop across the wrap.
        for (int i = 0; i < 60; i++) begin
            push = 1'b1; push_data = DATA_W'(200 + i);
            step();
        end
        push = 1'b0;
        chk("wrap_fill_count", count, 60);
        for (int k = 0; k < 10; k++) begin
            push = 1'b1; push_data = DATA_W'(100 + k); pop = 1'b1;
            #1;
            chk("wrap_waddr", ram_waddr, 64'((61 + k) % 64));
            step();
            chk("wrap_count", count, 60);
            chk("wrap_data", pop_data, 64'(200 + k));
        end
        push = 1'b0;
        for (int j = 0; j < 60; j++) begin
            pop = 1'b1;
            step();
            chk("wrap_drain", pop_data, (j < 50) ? 64'(210 + j) : 64'(100 + j - 50));
        end
        pop = 1'b0;
        chk("wrap_empty", empty, 1);

        // Full with simultaneous push+pop.
        for (int i = 0; i < 64; i++) begin
            push = 1'b1; push_data = DATA_W'(300 + i);
            step();
        end
        push_data = 32'd999; pop = 1'b1;
        #1;
        chk("fpp_we", ram_we, 0);
        chk("fpp_re", ram_re, 1);
        step();
        push = 1'b0; pop = 1'b0;
        chk("fpp_overflow", overflow, 1);
        chk("fpp_count", count, 63);
        chk("fpp_valid", pop_valid, 1);
        chk("fpp_data", pop_data, 300);

        // Push+pop while empty: push wins, pop rejected, no fall-through.
        do_reset();
        push = 1'b1; push_data = 32'd77; pop = 1'b1;
        #1;
        chk("epp_we", ram_we, 1);
        chk("epp_re", ram_re, 0);
        step();
        push = 1'b0; pop = 1'b0;
        chk("epp_underflow", underflow, 1);
        chk("epp_count", count, 1);
        chk("epp_valid", pop_valid, 0);

        // Reset mid-operation with a pending pop_valid.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = DATA_W'(50 + i);
            step();
        end
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        chk("mid_pre_valid", pop_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_valid", pop_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push = 1'b1; push_data = 32'd32;
        #1;
        chk("mid_waddr", ram_waddr, 0);
        step();
        push = 1'b0; pop = 1'b1;
        #1;
        chk("mid_raddr", ram_raddr, 0);
        step();
        pop = 1'b0;
        chk("mid_pop_valid", pop_valid, 1);
        chk("mid_pop_data", pop_data, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
